// File: rtl/polar_encode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : polar_encode_ctrl
//  Description : Frame controller around polar_transform. Accepts K info
//                bits, inserts frozen zeros to build the u vector, issues it
//                to the transform for one cycle, captures x and presents it
//                as a codeword. Includes a watchdog on the transform result
//                plus frame and timeout counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module polar_encode_ctrl #(
    parameter int              BITS        = 8,
    parameter int              K           = 4,
    parameter logic [BITS-1:0] FROZEN_MASK = 8'b0001_0111,
    parameter int              TIMEOUT     = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            info_valid,
    output logic            info_ready,
    input  logic [K-1:0]    info_data,
    output logic            pt_in_valid,
    output logic            pt_u [BITS],
    input  logic            pt_out_valid,
    input  logic            pt_x [BITS],
    output logic            code_valid,
    input  logic            code_ready,
    output logic [BITS-1:0] code_data,
    output logic            err,
    output logic [15:0]     frame_cnt,
    output logic [7:0]      err_cnt
);

    localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Position of u index idx within the info word: the number of
    // non-frozen indices strictly below it.
    function automatic int info_pos(input int idx);
        int n;
        n = 0;
        for (int b = 0; b < idx; b++) begin
            if (!FROZEN_MASK[b]) n++;
        end
        return n;
    endfunction

    state_t          state_q, state_d;
    logic [BITS-1:0] u_q, u_d;
    logic [BITS-1:0] code_q, code_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    logic [15:0]     frame_q, frame_d;
    logic [7:0]      errc_q, errc_d;

    logic [BITS-1:0] u_map;
    logic [BITS-1:0] x_packed;
    logic            accept;

    // A mask whose free positions do not match K can never map the info word.
    if ($countones(~FROZEN_MASK) != K) begin : g_mask_check
        $error("polar_encode_ctrl: popcount(~FROZEN_MASK) must equal K");
    end

    // Frozen positions are tied to zero; free positions take info bits in
    // ascending index order. Also packs the transform result.
    for (genvar i = 0; i < BITS; i++) begin : g_bits
        if (FROZEN_MASK[i]) begin : g_frozen
            assign u_map[i] = 1'b0;
        end else begin : g_info
            localparam int P = info_pos(i);
            assign u_map[i] = info_data[P];
        end
        assign pt_u[i]     = pt_in_valid & u_q[i];
        assign x_packed[i] = pt_x[i];
    end

    assign info_ready  = (state_q == IDLE) && !rst;
    assign pt_in_valid = (state_q == ISSUE);
    assign code_valid  = (state_q == HOLD);
    assign code_data   = code_q;
    assign err         = err_q;
    assign frame_cnt   = frame_q;
    assign err_cnt     = errc_q;
    assign accept      = info_valid && info_ready;

    // Next-state and datapath updates for the one-frame-in-flight sequence.
    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        code_d  = code_q;
        wd_d    = '0;
        err_d   = 1'b0;
        frame_d = frame_q;
        errc_d  = errc_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    u_d     = u_map;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // A result arriving on the timeout cycle still counts.
                if (pt_out_valid) begin
                    code_d  = x_packed;
                    frame_d = frame_q + 16'd1;
                    state_d = HOLD;
                end else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    errc_d  = (errc_q == 8'hFF) ? errc_q : errc_q + 8'd1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            HOLD: begin
                if (code_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            u_q     <= '0;
            code_q  <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            frame_q <= '0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            code_q  <= code_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            frame_q <= frame_d;
            errc_q  <= errc_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/polar_encode_ctrl.md
Name: polar_encode_ctrl

Overview:
- Frame controller wrapped around polar_transform.
- Accepts K information bits per frame over a valid/ready handshake and inserts frozen zeros according to a fixed frozen-bit mask, building the BITS-wide u vector.
- Issues u to polar_transform with a single-cycle in_valid, waits for out_valid, captures x, and presents it as a codeword over a valid/ready handshake.
- Also provides a watchdog for a missing out_valid and frame/error counters.

Parameters:
- BITS, 8, code length N (power of 2); must match the attached polar_transform.
- K, 4, information bits per frame; popcount(~FROZEN_MASK) must equal K.
- FROZEN_MASK, 8'b0001_0111, bit i = 1 means u[i] is frozen (forced 0).
- TIMEOUT, 64, maximum cycles in WAIT before declaring an error.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- info_valid  in  1  info word valid.
- info_ready  out  1  controller can accept an info word.
- info_data  in  K  info bits; bit j maps to the j-th non-frozen u index, in ascending index order.
- pt_in_valid  out  1  to polar_transform in_valid.
- pt_u  out  BITS (unpacked logic u[BITS])  to polar_transform u.
- pt_out_valid  in  1  from polar_transform out_valid.
- pt_x  in  BITS (unpacked logic x[BITS])  from polar_transform x.
- code_valid  out  1  codeword valid.
- code_ready  in  1  downstream accepts codeword.
- code_data  out  BITS  codeword; bit i = x[i].
- err  out  1  one-cycle pulse on watchdog timeout.
- frame_cnt  out  16  completed frames; wraps 0xFFFF->0.
- err_cnt  out  8  timeouts; saturates at 0xFF.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - State becomes IDLE.
  - info_ready=0 in the reset cycle, then 1 in IDLE.
  - pt_in_valid=0, pt_u all 0, code_valid=0, code_data=0, err=0, frame_cnt=0, err_cnt=0, watchdog=0.
  - Reset mid-frame abandons the frame; a later pt_out_valid is ignored.
- IDLE:
  - info_ready=1.
  - On info_valid&&info_ready: register the u vector, with frozen positions = 0 and info bits placed per mapping. Go to ISSUE.
- ISSUE (exactly 1 cycle):
  - pt_in_valid=1 and pt_u=frame vector. Go to WAIT.
  - Outside ISSUE, pt_u is all zeros and pt_in_valid=0.
- WAIT:
  - Watchdog increments each cycle.
  - If pt_out_valid=1: register pt_x into code_data, set code_valid=1, increment frame_cnt, clear the watchdog, go to HOLD.
  - Else if the watchdog reaches TIMEOUT-1: err=1 for one cycle, increment err_cnt, clear the watchdog, go to IDLE with no codeword.
  - If pt_out_valid and the timeout coincide, pt_out_valid wins.
- HOLD:
  - code_valid=1 and code_data stable until code_ready=1.
  - On the handshake cycle, go to IDLE; code_valid falls the next cycle. code_data keeps its last value.
- Other states: info_ready=0.
- pt_out_valid is ignored in every state except WAIT.
- Minimum frame period: 1 (accept) + 1 (ISSUE) + transform latency + 1 (HOLD with code_ready high).
- No back-to-back overlap: one frame in flight.
- Elaboration check: $error if popcount(~FROZEN_MASK[BITS-1:0]) != K.
- State encoding: enum IDLE, ISSUE, WAIT, HOLD.

Test Plan:
Defaults: BITS=8, K=4, mask 0x17 (info indices 3,5,6,7). Attached polar_transform computes x = u·F^{⊗3} with F=[[1,0],[1,1]], no bit reversal.
- Reset, then info_data=4'b0001 -> pt_u has only u[3]=1 during the single pt_in_valid cycle; code_data=8'h0F; frame_cnt=1.
- info_data=4'b1000, then 4'b0000 back-to-back with code_ready held high -> code_data 8'hFF, then 8'h00. pt_in_valid is exactly one cycle per frame; frame_cnt=2.
- code_ready held low 10 cycles after code_valid -> code_valid and code_data stable, info_ready=0, extra info_valid not accepted. Release -> one transfer only.
- pt_out_valid forced low (transform stubbed) -> err pulses exactly TIMEOUT cycles after entering WAIT; err_cnt=1; no code_valid; info_ready returns 1. Sweep all 16 info_data values afterwards against a software reference model.
- rst asserted in WAIT, then a stray pt_out_valid -> all outputs at reset values and no code_valid. Spurious pt_out_valid in IDLE -> ignored; frame_cnt unchanged.
